// File: rtl/sdram_write.sv
// ---------------------------------------------------------------------------
// sdram_write -- write-side command sequencer of the SDRAM controller.
//
// On wr_trig the block requests the bus from the arbiter, activates a row of
// bank 0 and streams back-to-back burst-4 WRITE commands over the whole
// 512-column row, for ROW_NUM rows starting at row 0. At each burst boundary
// it yields to a pending auto-refresh. It precharges and hands the bus back,
// then resumes at the same row and next burst once the bus is granted again.
//
// Parameters
//   ROW_NUM  rows written per job (1..8192)
//   T_RCD    ACTIVE-to-WRITE spacing in cycles (>= 2)
//   T_RP     PRECHARGE-to-next-command spacing in cycles (>= 2)
//
// Ports
//   sclk         controller clock
//   reset        synchronous, active-low reset (aborts any job)
//   wr_trig      start a write job (sampled only in IDLE)
//   wr_en        arbiter grant (sampled only in REQ)
//   ref_req      refresh pending from the refresh block
//   wr_req       bus request, high exactly while in REQ
//   flag_wr_end  one-cycle pulse when the bus is released
//   wr_data_req  read strobe to a show-ahead data FIFO, high while in WR
//   wr_data_in   write data, valid whenever wr_data_req is high
//   wr_cmd       {CS,RAS,CAS,WE}, registered
//   wr_addr      SDRAM address, registered
//   bank_addr    bank select, always bank 0
//   wr_data      DQ data, registered and aligned with wr_cmd
//
// Build option
//   SDRAM_WR_PATTERN_EN  when defined, wr_data carries an address pattern
//                        {row_cnt[6:0], burst_idx, beat} instead of the FIFO
//                        data; wr_data_in is ignored and wr_data_req stays 0.
// ---------------------------------------------------------------------------
module sdram_write #(
  parameter int ROW_NUM = 2,
  parameter int T_RCD   = 4,
  parameter int T_RP    = 4
) (
  input  logic        sclk,
  input  logic        reset,
  input  logic        wr_trig,
  input  logic        wr_en,
  input  logic        ref_req,
  output logic        wr_req,
  output logic        flag_wr_end,
  output logic        wr_data_req,
  input  logic [15:0] wr_data_in,
  output logic [3:0]  wr_cmd,
  output logic [12:0] wr_addr,
  output logic [1:0]  bank_addr,
  output logic [15:0] wr_data
);

  // One-hot state encoding.
  localparam logic [4:0] IDLE = 5'b00001;
  localparam logic [4:0] REQ  = 5'b00010;
  localparam logic [4:0] ACT  = 5'b00100;
  localparam logic [4:0] WR   = 5'b01000;
  localparam logic [4:0] PRE  = 5'b10000;

  // SDRAM commands as {CS,RAS,CAS,WE}.
  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_WR  = 4'b0100;
  localparam logic [3:0] CMD_PRE = 4'b0010;

  localparam int ACT_W = $clog2(T_RCD);
  localparam int PRE_W = $clog2(T_RP);

  localparam logic [ACT_W-1:0] ACT_LAST   = ACT_W'(T_RCD - 1);
  localparam logic [PRE_W-1:0] PRE_LAST   = PRE_W'(T_RP - 1);
  localparam logic [12:0]      ROW_LAST   = 13'(ROW_NUM - 1);
  localparam logic [6:0]       BURST_LAST = 7'd127;
  // A10 high selects all banks for the precharge.
  localparam logic [12:0]      PRE_ADDR   = 13'h0400;

  logic [4:0]       state;
  logic [12:0]      row_cnt;
  logic [6:0]       burst_idx;
  logic [ACT_W-1:0] act_cnt;
  logic [PRE_W-1:0] pre_cnt;
  logic [1:0]       beat;
  logic             job_done;
  logic             brk;
  logic             row_end;
  logic [15:0]      data_next;

  assign row_end   = (burst_idx == BURST_LAST);
  assign wr_req    = (state == REQ);
  assign bank_addr = 2'b00;

`ifdef SDRAM_WR_PATTERN_EN
  // Row bits plus the 9-bit column, so each beat is self-identifying.
  assign data_next   = {row_cnt[6:0], burst_idx, beat};
  assign wr_data_req = 1'b0;
`else
  assign data_next   = wr_data_in;
  assign wr_data_req = (state == WR);
`endif

  // NOTE: every register here is updated with non-blocking assignments so
  // that all decisions in a cycle see the values from before the clock edge.
  always_ff @(posedge sclk) begin
    if (!reset) begin
      state       <= IDLE;
      row_cnt     <= '0;
      burst_idx   <= '0;
      act_cnt     <= '0;
      pre_cnt     <= '0;
      beat        <= '0;
      job_done    <= 1'b0;
      brk         <= 1'b0;
      flag_wr_end <= 1'b0;
      wr_cmd      <= CMD_NOP;
      wr_addr     <= '0;
      wr_data     <= '0;
    end else begin
      // NOTE: defaulting the command and the pulse here makes every cycle
      // that issues nothing a NOP without repeating it in each branch.
      wr_cmd      <= CMD_NOP;
      flag_wr_end <= 1'b0;

      case (state)
        IDLE: begin
          if (wr_trig) begin
            row_cnt   <= '0;
            burst_idx <= '0;
            job_done  <= 1'b0;
            brk       <= 1'b0;
            state     <= REQ;
          end
        end

        REQ: begin
          if (wr_en) begin
            state <= ACT;
          end
        end

        ACT: begin
          if (act_cnt == '0) begin
            wr_cmd  <= CMD_ACT;
            wr_addr <= row_cnt;
          end
          if (act_cnt == ACT_LAST) begin
            act_cnt <= '0;
            beat    <= '0;
            state   <= WR;
          end else begin
            act_cnt <= act_cnt + 1'b1;
          end
        end

        WR: begin
          beat    <= beat + 1'b1;
          wr_data <= data_next;
          if (beat == 2'd0) begin
            // Column is burst_idx*4; A10 (inside the upper zeros) stays low
            // so there is no auto-precharge.
            wr_cmd  <= CMD_WR;
            wr_addr <= {4'b0000, burst_idx, 2'b00};
          end
          // Leaving WR only on the last beat keeps every burst whole.
          if (beat == 2'd3) begin
            burst_idx <= burst_idx + 1'b1;
            if (row_end && (row_cnt == ROW_LAST)) begin
              job_done <= 1'b1;
              state    <= PRE;
            end else if (row_end) begin
              row_cnt <= row_cnt + 1'b1;
              state   <= PRE;
            end else if (ref_req) begin
              brk   <= 1'b1;
              state <= PRE;
            end
          end
        end

        PRE: begin
          if (pre_cnt == '0) begin
            wr_cmd  <= CMD_PRE;
            wr_addr <= PRE_ADDR;
          end
          if (pre_cnt == PRE_LAST) begin
            pre_cnt <= '0;
            if (job_done) begin
              flag_wr_end <= 1'b1;
              state       <= IDLE;
            end else if (brk || ref_req) begin
              // Hand the bus back; row_cnt/burst_idx already point at the
              // resume position, and the row is re-activated after the grant.
              brk         <= 1'b0;
              flag_wr_end <= 1'b1;
              state       <= REQ;
            end else begin
              state <= ACT;
            end
          end else begin
            pre_cnt <= pre_cnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_write.sv
// ---------------------------------------------------------------------------
// tb_sdram_write -- randomized self-checking bench for sdram_write.
//
// A transaction-level model predicts, for every cycle, the command and
// address on wr_cmd/wr_addr, the data beats, wr_req, wr_data_req and
// flag_wr_end. The prediction follows the command timing rules (ACT one cycle
// after the grant, WR T_RCD after ACT, bursts 4 apart, PRE 4 after the last
// WR, next command T_RP after PRE). A counting show-ahead FIFO feeds
// wr_data_in.
// Jobs: 1) grant wait plus a directed refresh break at column 40,
// 2) random grant/refresh, 3) reset mid-WR, 4) random grant/refresh.
// ---------------------------------------------------------------------------
module tb_sdram_write;

  localparam int ROWS    = 2;
  localparam int TRCD    = 4;
  localparam int TRP     = 4;
  localparam int MAX_CYC = 20000;

  localparam logic [3:0] C_NOP = 4'b0111;
  localparam logic [3:0] C_ACT = 4'b0011;
  localparam logic [3:0] C_WR  = 4'b0100;
  localparam logic [3:0] C_PRE = 4'b0010;

  typedef enum logic [1:0] {M_IDLE, M_REQ, M_RUN} mphase_t;

  logic        sclk = 1'b0;
  logic        reset;
  logic        wr_trig;
  logic        wr_en;
  logic        ref_req;
  logic        wr_req;
  logic        flag_wr_end;
  logic        wr_data_req;
  logic [15:0] wr_data_in;
  logic [3:0]  wr_cmd;
  logic [12:0] wr_addr;
  logic [1:0]  bank_addr;
  logic [15:0] wr_data;

  sdram_write #(
    .ROW_NUM(ROWS),
    .T_RCD  (TRCD),
    .T_RP   (TRP)
  ) dut (
    .sclk       (sclk),
    .reset      (reset),
    .wr_trig    (wr_trig),
    .wr_en      (wr_en),
    .ref_req    (ref_req),
    .wr_req     (wr_req),
    .flag_wr_end(flag_wr_end),
    .wr_data_req(wr_data_req),
    .wr_data_in (wr_data_in),
    .wr_cmd     (wr_cmd),
    .wr_addr    (wr_addr),
    .bank_addr  (bank_addr),
    .wr_data    (wr_data)
  );

  always #5 sclk = ~sclk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  // ---------------- reference model state ----------------
  mphase_t     phase = M_IDLE;
  int          m_row, m_burst;
  bit          m_done, m_brk;
  bit          sc_valid;            // one scheduled command
  int          sc_time;
  logic [3:0]  sc_cmd;
  logic [12:0] sc_addr;
  bit          dc_valid;            // one pending decision point
  int          dc_time;
  bit          dc_pre;              // 1: end of precharge, 0: burst boundary
  bit          wr_seen;
  int          wr_last;
  int          d_row, d_burst;
  logic [15:0] exp_idx;
  bit          exp_flag;
  int          completions;

  // ---------------- stimulus state ----------------
  logic [15:0] fifo_head;
  int          jobs_started;
  int          en_hold, ref_hold, rst_hold, idle_gap;
  bit          dir_ref, brk_done, rst_done, resume_chk;
  bit          rst_v, trig_v, en_v, ref_v;

  task automatic schedule(input int t, input logic [3:0] c, input logic [12:0] a);
    sc_valid = 1'b1;
    sc_time  = t;
    sc_cmd   = c;
    sc_addr  = a;
  endtask

  // Advance the model by the clock edge that produced sample cyc.
  task automatic model_step();
    exp_flag = 1'b0;
    if (!rst_v) begin
      phase    = M_IDLE;
      sc_valid = 1'b0;
      dc_valid = 1'b0;
      wr_seen  = 1'b0;
    end else begin
      case (phase)
        M_IDLE: if (trig_v) begin
          phase   = M_REQ;
          m_row   = 0;
          m_burst = 0;
          m_done  = 1'b0;
          m_brk   = 1'b0;
          exp_idx = fifo_head;
        end
        M_REQ: if (en_v) begin
          phase = M_RUN;
          schedule(cyc + 1, C_ACT, 13'(m_row));
        end
        default: if (dc_valid && dc_time == cyc) begin
          dc_valid = 1'b0;
          if (!dc_pre) begin
            if (m_burst == 127 && m_row == ROWS - 1) begin
              m_done = 1'b1;
              schedule(cyc + 1, C_PRE, 13'h0400);
            end else if (m_burst == 127) begin
              m_row++;
              m_burst = 0;
              schedule(cyc + 1, C_PRE, 13'h0400);
            end else begin
              m_burst++;
              if (ref_v) begin
                m_brk = 1'b1;
                schedule(cyc + 1, C_PRE, 13'h0400);
              end else begin
                schedule(cyc + 1, C_WR, 13'(m_burst * 4));
              end
            end
          end else begin
            if (m_done) begin
              phase    = M_IDLE;
              exp_flag = 1'b1;
              completions++;
            end else if (m_brk || ref_v) begin
              m_brk    = 1'b0;
              phase    = M_REQ;
              exp_flag = 1'b1;
            end else begin
              schedule(cyc + 1, C_ACT, 13'(m_row));
            end
          end
        end
      endcase
    end
  endtask

  task automatic sample_checks();
    logic [3:0]  cmd_now;
    logic [15:0] exp_d;
    bit          exp_req;
    int          b;
    check("wr_req", wr_req, (phase == M_REQ));
    check("flag_wr_end", flag_wr_end, exp_flag);
    check("bank_addr", bank_addr, 0);
    if (sc_valid && sc_time == cyc) begin
      sc_valid = 1'b0;
      cmd_now  = sc_cmd;
      check("cmd", wr_cmd, cmd_now);
      check("addr", wr_addr, sc_addr);
      if (cmd_now == C_ACT) begin
        schedule(cyc + TRCD, C_WR, 13'(m_burst * 4));
      end else if (cmd_now == C_WR) begin
        wr_seen  = 1'b1;
        wr_last  = cyc;
        d_row    = m_row;
        d_burst  = m_burst;
        dc_valid = 1'b1;
        dc_time  = cyc + 3;
        dc_pre   = 1'b0;
        if (resume_chk) begin
          check("resume_col", wr_addr, 13'd44);
          resume_chk = 1'b0;
        end
        if (jobs_started == 1 && m_burst == 10 && !brk_done) begin
          dir_ref  = 1'b1;
          brk_done = 1'b1;
        end
        if (jobs_started == 3 && m_burst == 20 && !rst_done) begin
          rst_hold = 3;
          rst_done = 1'b1;
        end
      end else begin
        dc_valid = 1'b1;
        dc_time  = cyc + TRP - 1;
        dc_pre   = 1'b1;
      end
    end else begin
      check("cmd_nop", wr_cmd, C_NOP);
    end
    if (wr_seen && cyc <= wr_last + 3) begin
      b = cyc - wr_last;
`ifdef SDRAM_WR_PATTERN_EN
      exp_d = {d_row[6:0], d_burst[6:0], b[1:0]};
`else
      exp_d   = exp_idx;
      exp_idx = exp_idx + 16'd1;
`endif
      check("wr_data", wr_data, exp_d);
    end
`ifdef SDRAM_WR_PATTERN_EN
    exp_req = 1'b0;
`else
    exp_req = (sc_valid && sc_cmd == C_WR && sc_time == cyc + 1) ||
              (wr_seen && cyc <= wr_last + 2);
`endif
    check("wr_data_req", wr_data_req, exp_req);
    if (!rst_v) begin
      check("rst_addr", wr_addr, 0);
      check("rst_data", wr_data, 0);
    end
    // Directed break served: keep the grant away for 20 cycles.
    if (exp_flag && phase == M_REQ && dir_ref) begin
      dir_ref    = 1'b0;
      en_hold    = 20;
      resume_chk = 1'b1;
    end
    if (exp_flag && phase == M_IDLE) idle_gap = $urandom_range(0, 5);
    if (!rst_v) idle_gap = 2;
  endtask

  // Inputs for the next rising edge, driven at the falling edge.
  task automatic drive_next();
    wr_data_in = fifo_head;
    if (wr_data_req) fifo_head = fifo_head + 16'd1;

    if (rst_hold > 0) begin
      reset = 1'b0;
      rst_hold--;
    end else begin
      reset = 1'b1;
    end

    wr_trig = 1'b0;
    if (phase == M_IDLE) begin
      if (reset && idle_gap == 0 && jobs_started < 4) begin
        wr_trig = 1'b1;
        jobs_started++;
        if (jobs_started == 1) en_hold = 10;
      end else if (idle_gap > 0) begin
        idle_gap--;
      end
    end else if ($urandom_range(0, 63) == 0) begin
      wr_trig = 1'b1;   // ignored outside IDLE
    end

    if (en_hold > 0) begin
      wr_en = 1'b0;
      en_hold--;
    end else if (jobs_started == 1) begin
      wr_en = 1'b1;
    end else begin
      wr_en = ($urandom_range(0, 3) == 0);
    end

    if (jobs_started >= 2 && ref_hold == 0 && $urandom_range(0, 59) == 0)
      ref_hold = $urandom_range(1, 6);
    ref_req = dir_ref || (ref_hold > 0);
    if (ref_hold > 0) ref_hold--;
  endtask

  initial begin
    reset      = 1'b0;
    wr_trig    = 1'b0;
    wr_en      = 1'b0;
    ref_req    = 1'b0;
    wr_data_in = '0;
    fifo_head  = '0;
    rst_hold   = 1;
    idle_gap   = 2;
    for (int i = 0; i < MAX_CYC; i++) begin
      rst_v  = reset;
      trig_v = wr_trig;
      en_v   = wr_en;
      ref_v  = ref_req;
      @(posedge sclk);
      @(negedge sclk);
      cyc++;
      model_step();
      sample_checks();
      if ((completions == 3 && phase == M_IDLE) || n_fail >= 40) break;
      drive_next();
    end
    check("jobs_completed", completions, 3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
